// File: rtl/i2c_slave_regctl.sv
// ---------------------------------------------------------------------------
// i2c_slave_regctl
// Register-bank controller behind an I2C slave. The slave's address, write
// and read strobes arrive from the SCL domain. They are synchronised into clk
// and turned into one-cycle events. A small FSM then steers the bytes into an
// auto-incrementing register pointer and the register file.
// A fabric-side port shares the same register file. When an I2C write
// commits, the I2C side wins and the local access waits one cycle.
// ---------------------------------------------------------------------------
module i2c_slave_regctl #(
  parameter int                N_REGS  = 16,
  parameter int                AW      = 4,
  parameter logic [N_REGS-1:0] RO_MASK = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_in,
  // I2C slave side (strobes are asynchronous to clk)
  input  logic          i2c_as,
  input  logic          i2c_ws,
  input  logic          i2c_rs,
  input  logic [7:0]    i2c_dat,
  output logic [7:0]    i2c_din,
  // Local fabric access port
  input  logic          loc_req,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic          loc_ack,
  output logic [7:0]    loc_rdata,
  // Write notification
  output logic          irq_wr,
  output logic [AW-1:0] wr_addr
);

  // Transaction states
  localparam logic [1:0] ST_IDLE = 2'd0;  // no transaction in progress
  localparam logic [1:0] ST_PTR  = 2'd1;  // next written byte is the pointer
  localparam logic [1:0] ST_WDAT = 2'd2;  // written bytes go to reg[ptr]
  localparam logic [1:0] ST_RDAT = 2'd3;  // slave transmits reg[ptr]

  // Register count, widened so that N_REGS == 2**AW is still representable.
  localparam logic [AW:0] N_REGS_W = (AW+1)'(N_REGS);

  // -------------------------------------------------------------------------
  // Pointer arithmetic: everything wraps modulo N_REGS.
  // -------------------------------------------------------------------------
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    logic [AW:0] nxt;
    nxt = {1'b0, p} + (AW+1)'(1);
    return (nxt >= N_REGS_W) ? '0 : nxt[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] ptr_mod(input logic [AW-1:0] v);
    logic [AW:0] m;
    m = {1'b0, v} % N_REGS_W;
    return m[AW-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Strobe synchronisers: two metastability flops and one history flop.
  // An event fires on the cycle the second flop rises. The FSM acts on it
  // at the next edge, three clocks after the strobe rose.
  // -------------------------------------------------------------------------
  logic [2:0] as_sync;
  logic [2:0] ws_sync;
  logic [2:0] rs_sync;

  // Shift the three asynchronous strobes into the clk domain
  always_ff @(posedge clk) begin
    // NOTE: every flop in an always_ff uses <=. All right-hand sides then
    // see the values from before the edge, so the chain behaves as a real
    // shift register no matter how the statements are ordered.
    if (rst_in) begin
      as_sync <= '0;
      ws_sync <= '0;
      rs_sync <= '0;
    end else begin
      as_sync <= {as_sync[1:0], i2c_as};
      ws_sync <= {ws_sync[1:0], i2c_ws};
      rs_sync <= {rs_sync[1:0], i2c_rs};
    end
  end

  logic as_raw;
  logic ws_raw;
  logic rs_raw;

  assign as_raw = as_sync[1] & ~as_sync[2];
  assign ws_raw = ws_sync[1] & ~ws_sync[2];
  assign rs_raw = rs_sync[1] & ~rs_sync[2];

  // -------------------------------------------------------------------------
  // Event priority and write-commit decode
  // -------------------------------------------------------------------------
  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic          as_evt;
  logic          ws_evt;
  logic          rs_evt;
  logic          i2c_commit;
  logic          loc_accept;
  logic          loc_in_range;

  // When events coincide, apply the priority as > ws > rs
  always_comb begin
    // NOTE: each output gets a default before any condition, so there is
    // no path that leaves one unassigned. An unassigned path would infer
    // a latch.
    as_evt     = 1'b0;
    ws_evt     = 1'b0;
    rs_evt     = 1'b0;
    i2c_commit = 1'b0;
    if (as_raw) begin
      as_evt = 1'b1;
    end else if (ws_raw) begin
      ws_evt = 1'b1;
    end else if (rs_raw) begin
      rs_evt = 1'b1;
    end
    // A data byte in WDAT writes reg[ptr] only when the register is not read-only
    if (ws_evt && (state == ST_WDAT) && !RO_MASK[ptr]) begin
      i2c_commit = 1'b1;
    end
  end

  // A local access goes through on any cycle with no I2C commit
  assign loc_accept = loc_req & ~i2c_commit;

  if (N_REGS >= (1 << AW)) begin : g_full_range
    assign loc_in_range = 1'b1;
  end else begin : g_part_range
    assign loc_in_range = ({1'b0, loc_addr} < N_REGS_W);
  end

  // -------------------------------------------------------------------------
  // Transaction FSM and auto-incrementing pointer
  // -------------------------------------------------------------------------
  // Sequence address/data/ack events into state and pointer updates
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else if (as_evt) begin
      // A (repeated) start from any state. The R/W bit picks the direction
      // and the pointer is kept.
      state <= i2c_dat[0] ? ST_RDAT : ST_PTR;
    end else if (ws_evt) begin
      case (state)
        ST_PTR: begin
          ptr   <= ptr_mod(i2c_dat[AW-1:0]);
          state <= ST_WDAT;
        end
        ST_WDAT: ptr <= ptr_inc(ptr);  // advances even over read-only regs
        default: ;                     // IDLE/RDAT: byte ignored
      endcase
    end else if (rs_evt && (state == ST_RDAT)) begin
      ptr <= ptr_inc(ptr);
    end
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [7:0] regs [N_REGS];

  // Apply I2C commits and accepted local writes (never both in one cycle)
  always_ff @(posedge clk) begin
    // NOTE: the register file is reset element by element because its
    // contents must read back as zero after reset. Without that it could
    // have been left unreset and mapped onto RAM.
    if (rst_in) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (i2c_commit) begin
        regs[ptr] <= i2c_dat;
      end
      if (loc_accept && loc_we && loc_in_range) begin
        regs[loc_addr] <= loc_wdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Local port handshake: ack the cycle after accept, capture read data
  always_ff @(posedge clk) begin
    if (rst_in) begin
      loc_ack   <= 1'b0;
      loc_rdata <= '0;
    end else begin
      loc_ack <= loc_accept;
      if (loc_accept && !loc_we) begin
        loc_rdata <= loc_in_range ? regs[loc_addr] : 8'h00;
      end
    end
  end

  // Flag each committed I2C write and remember where it landed
  always_ff @(posedge clk) begin
    if (rst_in) begin
      irq_wr  <= 1'b0;
      wr_addr <= '0;
    end else begin
      irq_wr <= i2c_commit;
      if (i2c_commit) begin
        wr_addr <= ptr;
      end
    end
  end

  // Present reg[ptr] to the slave, one clock behind pointer/data changes
  always_ff @(posedge clk) begin
    if (rst_in) begin
      i2c_din <= '0;
    end else begin
      i2c_din <= regs[ptr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regctl.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regctl
// Self-checking bench. A transaction-level model of the register bank holds
// the registers, the pointer, the protocol state and the expected write
// notifications. It is updated once per I2C byte or local access. One
// compare process checks the DUT against it every quiet cycle, and literal
// expectations pin the model on the directed scenarios.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regctl;

  localparam int          N  = 16;
  localparam int          AW = 4;
  localparam logic [15:0] RO = 16'h0004;  // reg2 is read-only from I2C

  logic          clk = 1'b0;
  logic          rst_in;
  logic          i2c_as, i2c_ws, i2c_rs;
  logic [7:0]    i2c_dat;
  logic [7:0]    i2c_din;
  logic          loc_req, loc_we;
  logic [AW-1:0] loc_addr;
  logic [7:0]    loc_wdata;
  logic          loc_ack;
  logic [7:0]    loc_rdata;
  logic          irq_wr;
  logic [AW-1:0] wr_addr;

  always #5 clk = ~clk;

  i2c_slave_regctl #(.N_REGS(N), .AW(AW), .RO_MASK(RO)) dut (
    .clk(clk), .rst_in(rst_in),
    .i2c_as(i2c_as), .i2c_ws(i2c_ws), .i2c_rs(i2c_rs),
    .i2c_dat(i2c_dat), .i2c_din(i2c_din),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_ack(loc_ack), .loc_rdata(loc_rdata),
    .irq_wr(irq_wr), .wr_addr(wr_addr)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_PTR, M_WDAT, M_RDAT} mstate_t;
  typedef enum {K_AS, K_WS, K_RS} kind_t;

  logic [7:0] m_regs [N];
  int         m_ptr;
  mstate_t    m_state;
  int         exp_irq [$];
  bit         quiet    = 1'b0;
  bit         in_reset = 1'b1;
  int         irq_seen = 0;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    m_ptr   = 0;
    m_state = M_IDLE;
    exp_irq.delete();
  endfunction

  function automatic void m_apply(input kind_t k, input logic [7:0] dat);
    case (k)
      K_AS: m_state = dat[0] ? M_RDAT : M_PTR;
      K_WS: begin
        if (m_state == M_PTR) begin
          m_ptr   = (int'(dat) % (1 << AW)) % N;
          m_state = M_WDAT;
        end else if (m_state == M_WDAT) begin
          if (!RO[m_ptr]) begin
            m_regs[m_ptr] = dat;
            exp_irq.push_back(m_ptr);
          end
          m_ptr = (m_ptr + 1) % N;
        end
      end
      K_RS: if (m_state == M_RDAT) m_ptr = (m_ptr + 1) % N;
      default: ;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!in_reset) begin
      if (quiet) begin
        check("i2c_din", i2c_din, m_regs[m_ptr]);
        check("loc_ack_idle", loc_ack, 0);
      end
      if (irq_wr) begin
        irq_seen++;
        if (exp_irq.size() == 0) check("irq_wr_unexpected", irq_wr, 0);
        else check("wr_addr", wr_addr, exp_irq.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input kind_t k, input logic [7:0] dat);
    quiet = 1'b0;
    m_apply(k, dat);
    i2c_dat = dat;
    case (k)
      K_AS: i2c_as = 1'b1;
      K_WS: i2c_ws = 1'b1;
      default: i2c_rs = 1'b1;
    endcase
    step($urandom_range(3, 6));
    i2c_as = 1'b0;
    i2c_ws = 1'b0;
    i2c_rs = 1'b0;
    step(6);
    check("irq_pending", exp_irq.size(), 0);
    quiet = 1'b1;
  endtask

  task automatic loc_access(input bit we, input logic [AW-1:0] addr,
                            input logic [7:0] wdata, output logic [7:0] rdata);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    quiet     = 1'b0;
    loc_req   = 1'b1;
    loc_we    = we;
    loc_addr  = addr;
    loc_wdata = wdata;
    while (!got && n < 10) begin
      step(1);
      n++;
      if (loc_ack) got = 1'b1;
    end
    loc_req = 1'b0;
    check("loc_ack_seen", got, 1);
    rdata = loc_rdata;
    if (we) m_regs[addr] = wdata;
    else check("loc_rdata", loc_rdata, m_regs[addr]);
    step(1);
    quiet = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rd;
    int irq0;

    rst_in = 1'b1; i2c_as = 1'b0; i2c_ws = 1'b0; i2c_rs = 1'b0; i2c_dat = 8'h00;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = 8'h00;
    m_reset();
    step(4);
    rst_in = 1'b0;
    in_reset = 1'b0;
    step(1);
    check("rst_i2c_din", i2c_din, 8'h00);
    check("rst_loc_ack", loc_ack, 0);
    check("rst_loc_rdata", loc_rdata, 8'h00);
    check("rst_irq_wr", irq_wr, 0);
    check("rst_wr_addr", wr_addr, 0);
    quiet = 1'b1;

    // Basic write burst through the pointer
    irq0 = irq_seen;
    strobe(K_AS, 8'h76); strobe(K_WS, 8'h03); strobe(K_WS, 8'hA5); strobe(K_WS, 8'h5A);
    check("burst_irq_count", irq_seen - irq0, 2);
    check("burst_wr_addr_last", wr_addr, 4);
    loc_access(1'b0, 4'd3, 8'h00, rd); check("burst_reg3", rd, 8'hA5);
    loc_access(1'b0, 4'd4, 8'h00, rd); check("burst_reg4", rd, 8'h5A);

    // Pointer wrap from 15 to 0
    strobe(K_AS, 8'h76); strobe(K_WS, 8'h0F); strobe(K_WS, 8'hAA); strobe(K_WS, 8'hBB);
    check("wrap_ptr_din", i2c_din, 8'h00);
    loc_access(1'b0, 4'd15, 8'h00, rd); check("wrap_reg15", rd, 8'hAA);
    loc_access(1'b0, 4'd0, 8'h00, rd);  check("wrap_reg0", rd, 8'hBB);

    // Read transaction after a repeated start
    loc_access(1'b1, 4'd7, 8'h11, rd);
    loc_access(1'b1, 4'd8, 8'h22, rd);
    strobe(K_AS, 8'h76); strobe(K_WS, 8'h07); strobe(K_AS, 8'h77);
    check("read_din_reg7", i2c_din, 8'h11);
    quiet = 1'b0;
    m_apply(K_RS, 8'h77);
    i2c_rs = 1'b1;
    step(5);
    check("read_din_reg8_5clk", i2c_din, 8'h22);
    i2c_rs = 1'b0;
    step(6);
    quiet = 1'b1;

    // Read-only register
    irq0 = irq_seen;
    strobe(K_AS, 8'h76); strobe(K_WS, 8'h02); strobe(K_WS, 8'hFF);
    check("ro_no_irq", irq_seen - irq0, 0);
    check("ro_ptr_din", i2c_din, 8'hA5);
    loc_access(1'b0, 4'd2, 8'h00, rd); check("ro_reg2_kept", rd, 8'h00);
    loc_access(1'b1, 4'd2, 8'h42, rd);
    loc_access(1'b0, 4'd2, 8'h00, rd); check("ro_reg2_local", rd, 8'h42);

    // Local write colliding with an I2C commit to the same register
    strobe(K_AS, 8'h76); strobe(K_WS, 8'h05);
    quiet = 1'b0;
    m_apply(K_WS, 8'h33);
    i2c_dat = 8'h33;
    i2c_ws  = 1'b1;
    step(2);
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 4'd5; loc_wdata = 8'h99;
    step(1);
    check("coll_ack_stalled", loc_ack, 0);
    step(1);
    check("coll_ack_late", loc_ack, 1);
    loc_req = 1'b0;
    m_regs[5] = 8'h99;
    step(2);
    i2c_ws = 1'b0;
    step(6);
    check("coll_irq_pending", exp_irq.size(), 0);
    quiet = 1'b1;
    loc_access(1'b0, 4'd5, 8'h00, rd); check("coll_reg5", rd, 8'h99);

    // Reset in the middle of a transaction
    strobe(K_AS, 8'h76);
    quiet = 1'b0;
    in_reset = 1'b1;
    rst_in = 1'b1;
    step(2);
    rst_in = 1'b0;
    in_reset = 1'b0;
    m_reset();
    irq0 = irq_seen;
    strobe(K_WS, 8'h03); strobe(K_WS, 8'h44);
    check("rstmid_no_irq", irq_seen - irq0, 0);
    check("rstmid_din", i2c_din, 8'h00);
    loc_access(1'b0, 4'd3, 8'h00, rd); check("rstmid_reg3", rd, 8'h00);
    loc_access(1'b0, 4'd4, 8'h00, rd); check("rstmid_reg4", rd, 8'h00);

    // Randomised mix of I2C bytes and local accesses
    for (int it = 0; it < 300; it++) begin
      int r;
      logic [7:0] d;
      logic [AW-1:0] a;
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      a = AW'($urandom_range(0, N - 1));
      if (r < 2)      strobe(K_AS, d);
      else if (r < 6) strobe(K_WS, d);
      else if (r < 8) strobe(K_RS, d);
      else            loc_access(r[0], a, d, rd);
    end

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
